// File: rtl/modexp_pkg.sv
// Shared definitions for the modexp datapath: default width, Montgomery exponent, FSM encoding.
// Used by mm_setup, the mm_mult blocks and mm_exit.
package modexp_pkg;
    localparam int W_DEF = 16;
    localparam int R_EXP = W_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/mm_redc_step.sv
// One bit-serial REDC step: t_nxt = (t + t[0]*n) >> 1, combinational.
// Sum carried in W+2 bits so the carry out of t+n is never lost.
module mm_redc_step #(
    parameter int W = 16
) (
    input  logic [W:0]   t,
    input  logic [W-1:0] n,
    output logic [W:0]   t_nxt
);
    logic [W+1:0] sum;

    always_comb begin
        sum   = {1'b0, t} + (t[0] ? {2'b00, n} : '0);
        t_nxt = (W+1)'(sum >> 1);
    end
endmodule

// File: rtl/mm_exit.sv
// Montgomery-domain exit: x = a * 2^-W mod n via W REDC steps plus one conditional subtract.
// Latency W+2 enabled edges from start to ready; ce low freezes everything, start ignored while busy.
module mm_exit
    import modexp_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         start,
    input  logic [W-1:0] n,
    input  logic [W-1:0] a,
    output logic [W-1:0] x,
    output logic         ready,
    output logic         busy,
    output logic         err
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t         state;
    logic [W:0]     t;
    logic [W:0]     t_nxt;
    logic [W-1:0]   n_q;
    logic [CW-1:0]  cnt;

    mm_redc_step #(.W(W)) u_step (
        .t     (t),
        .n     (n_q),
        .t_nxt (t_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            t     <= '0;
            n_q   <= '0;
            cnt   <= '0;
            x     <= '0;
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (n[0]) begin
                            t     <= {1'b0, a};
                            n_q   <= n;
                            cnt   <= '0;
                            ready <= 1'b0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end else begin
                            // Even modulus has no inverse of R; flag it without running.
                            x     <= '0;
                            err   <= 1'b1;
                            ready <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    t   <= t_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= FIX;
                end
                FIX: begin
                    // After W steps t <= n, so one subtract lands in [0, n).
                    x     <= (t >= {1'b0, n_q}) ? W'(t - {1'b0, n_q}) : W'(t);
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
